// File: rtl/bitserial_mac_accum_if.sv
// Bus between the bit-plane multiplier array and the bit-serial MAC back end.
// Carries the plane beats in, and the finished dot products and framing errors out.
`default_nettype none

interface bitserial_mac_accum_if #(
  parameter int N_IN     = 32,
  parameter int IN_W     = 4,
  parameter int MAX_BITS = 8
);
  localparam int LOG2N = $clog2(N_IN);
  localparam int S_W   = IN_W + LOG2N;
  localparam int OUT_W = S_W + MAX_BITS + 1;

  logic                   in_valid;
  logic                   in_first;
  logic                   in_last;
  logic                   signed_mode;
  logic [N_IN*IN_W-1:0]   in_data;
  logic                   out_valid;
  logic [OUT_W-1:0]       out_data;
  logic                   proto_err;

  modport master (
    output in_valid, in_first, in_last, signed_mode, in_data,
    input  out_valid, out_data, proto_err
  );

  modport slave (
    input  in_valid, in_first, in_last, signed_mode, in_data,
    output out_valid, out_data, proto_err
  );
endinterface

`default_nettype wire

// File: rtl/bitserial_mac_accum.sv
// Bit-serial MAC back end: pipelined lane adder tree per bit-plane, followed by an
// MSB-first shift-accumulator producing one signed dot product per frame.
`default_nettype none

module bitserial_mac_accum #(
  parameter int N_IN     = 32,
  parameter int IN_W     = 4,
  parameter int MAX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitserial_mac_accum_if.slave  bus
);
  localparam int LOG2N = $clog2(N_IN);
  localparam int S_W   = IN_W + LOG2N;
  localparam int OUT_W = S_W + MAX_BITS + 1;
  localparam int CNT_W = $clog2(MAX_BITS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPEN = 2'd1;
  localparam logic [1:0] ST_BAD  = 2'd2;

  // Level j holds N_IN>>j nodes of IN_W+j bits; level 0 is the raw input.
  for (genvar j = 0; j <= LOG2N; j++) begin : g_lvl
    localparam int W     = IN_W + j;
    localparam int NODES = N_IN >> j;
    logic [NODES*W-1:0] node;

    if (j == 0) begin : g_in
      assign node = bus.in_data;
    end else begin : g_add
      for (genvar k = 0; k < NODES; k++) begin : g_node
        logic [W-1:0] sum;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sum <= '0;
          end else begin
            sum <= {1'b0, g_lvl[j-1].node[(2*k)*(W-1) +: W-1]}
                 + {1'b0, g_lvl[j-1].node[(2*k+1)*(W-1) +: W-1]};
          end
        end
        assign node[k*W +: W] = sum;
      end
    end
  end

  // {valid, first, last, signed_mode} aligned with the tree output.
  logic [3:0] flag_pipe [LOG2N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOG2N; i++) flag_pipe[i] <= '0;
    end else begin
      flag_pipe[0] <= {bus.in_valid, bus.in_first, bus.in_last, bus.signed_mode};
      for (int i = 1; i < LOG2N; i++) flag_pipe[i] <= flag_pipe[i-1];
    end
  end

  logic             beat_valid;
  logic             beat_first;
  logic             beat_last;
  logic             beat_signed;
  logic [S_W-1:0]   plane;
  logic [OUT_W-1:0] plane_ext;

  assign {beat_valid, beat_first, beat_last, beat_signed} = flag_pipe[LOG2N-1];
  assign plane     = g_lvl[LOG2N].node;
  assign plane_ext = {{(OUT_W-S_W){1'b0}}, plane};

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             done;
  logic             err;
  logic             res_valid;
  logic [OUT_W-1:0] res_data;
  logic             err_pulse;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    done     = 1'b0;
    err      = 1'b0;
    if (beat_valid) begin
      if (beat_first) begin
        // A restart inside an open frame discards it; if this beat also closes,
        // the error wins so the result and the error never share a beat.
        err    = (state != ST_IDLE);
        acc_nx = beat_signed ? (~plane_ext + OUT_W'(1)) : plane_ext;
        cnt_nx = CNT_W'(1);
        if (beat_last) begin
          state_nx = ST_IDLE;
          done     = (state == ST_IDLE);
        end else begin
          state_nx = ST_OPEN;
        end
      end else begin
        case (state)
          ST_IDLE: err = 1'b1;
          ST_OPEN: begin
            if (cnt == CNT_W'(MAX_BITS)) begin
              err      = 1'b1;
              state_nx = beat_last ? ST_IDLE : ST_BAD;
            end else begin
              acc_nx = (acc << 1) + plane_ext;
              cnt_nx = cnt + CNT_W'(1);
              if (beat_last) begin
                done     = 1'b1;
                state_nx = ST_IDLE;
              end
            end
          end
          ST_BAD: begin
            if (beat_last) state_nx = ST_IDLE;
          end
          default: state_nx = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      res_valid <= done;
      err_pulse <= err;
      if (done) res_data <= acc_nx;
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;
  assign bus.proto_err = err_pulse;
endmodule

`default_nettype wire

// File: tb/tb_bitserial_mac_accum.sv
// Bench for bitserial_mac_accum: table of frames plus hand-written framing/reset sequences,
// results and error pulses checked against scoreboard queues of value and arrival cycle.
`default_nettype none

module tb_bitserial_mac_accum;
  localparam int N_IN     = 32;
  localparam int IN_W     = 4;
  localparam int MAX_BITS = 8;
  localparam int LOG2N    = 5;
  localparam int OUT_W    = IN_W + LOG2N + MAX_BITS + 1;
  localparam int LAT      = LOG2N + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitserial_mac_accum_if #(.N_IN(N_IN), .IN_W(IN_W), .MAX_BITS(MAX_BITS)) bus ();

  bitserial_mac_accum #(.N_IN(N_IN), .IN_W(IN_W), .MAX_BITS(MAX_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int  data;
    int  cyc;
  } exp_t;

  // Each plane: lane 0 = a[p], lanes 1..31 = b[p], so plane sum = a + 31*b.
  typedef struct {
    int  n;
    bit  sgn;
    int  gap;
    int  a [8];
    int  b [8];
    int  exp_v;
  } vec_t;

  exp_t q[$];
  int   errq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_res = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic signed [OUT_W-1:0] od;
  exp_t                    e;
  int                      ec;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected out_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e  = q.pop_front();
          od = bus.out_data;
          chk("out_data", longint'(od), e.data);
          chk("out_latency", cyc, e.cyc);
        end
      end
      if (bus.proto_err) begin
        if (errq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected proto_err: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          ec = errq.pop_front();
          chk("proto_err_cycle", cyc, ec);
        end
      end
    end
  end

  task automatic beat(input bit v, input bit f, input bit l, input bit s, input int a, input int b);
    @(posedge clk); #1;
    bus.in_valid    = v;
    bus.in_first    = f;
    bus.in_last     = l;
    bus.signed_mode = s;
    for (int k = 0; k < N_IN; k++)
      bus.in_data[k*IN_W +: IN_W] = (k == 0) ? IN_W'(a) : IN_W'(b);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic expect_res(input int v);
    exp_t x;
    x.data = v;
    x.cyc  = cyc + LAT;
    q.push_back(x);
    last_res = v;
  endtask

  vec_t vecs [9];
  logic signed [OUT_W-1:0] hold;

  initial begin
    vecs[0] = '{8, 1'b0, 0, '{default:15}, '{default:15}, 122400};
    vecs[1] = '{8, 1'b1, 0, '{0:15, default:0}, '{0:15, default:0}, -61440};
    vecs[2] = '{1, 1'b0, 0, '{0:5, default:0}, '{default:0}, 5};
    vecs[3] = '{8, 1'b0, 3, '{default:1}, '{default:0}, 255};
    vecs[4] = '{8, 1'b1, 0, '{default:15}, '{default:15}, -480};
    vecs[5] = '{2, 1'b0, 0, '{0:3, default:0}, '{0:2, 1:1, default:0}, 161};
    vecs[6] = '{3, 1'b1, 0, '{0:1, 1:0, 2:7, default:0}, '{default:0}, 3};
    vecs[7] = '{1, 1'b1, 0, '{0:5, default:0}, '{default:0}, -5};
    vecs[8] = '{4, 1'b0, 1, '{default:15}, '{default:0}, 225};

    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0; bus.signed_mode = 0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset proto_err", bus.proto_err, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int p = 0; p < vecs[i].n; p++) begin
        beat(1'b1, p == 0, p == vecs[i].n - 1, vecs[i].sgn, vecs[i].a[p], vecs[i].b[p]);
        if (p == vecs[i].n - 1) expect_res(vecs[i].exp_v);
        else idle(vecs[i].gap);
      end
    end

    // Over-long frames: the ninth plane flags once, the frame closes silently.
    for (int n = 9; n <= 10; n++) begin
      for (int p = 0; p < n; p++) begin
        beat(1'b1, p == 0, p == n - 1, 1'b0, 1, 0);
        if (p == 8) errq.push_back(cyc + LAT);
      end
      beat(1'b1, 1'b1, 1'b0, 1'b0, 3, 2);
      beat(1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
      expect_res(161);
    end

    // Restart inside an open frame: the new frame is the one reported.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    beat(1'b1, 1'b1, 1'b0, 1'b0, 2, 0);
    errq.push_back(cyc + LAT);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 1, 0);
    expect_res(5);

    // Orphan last and middle beats with no frame open.
    beat(1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    errq.push_back(cyc + LAT);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
    errq.push_back(cyc + LAT);
    idle(2);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 7, 0);
    expect_res(7);

    // Reset with a frame in flight in the tree.
    idle(LAT + 2);
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", bus.out_valid, 0);
    chk("midreset out_data", bus.out_data, 0);
    chk("midreset proto_err", bus.proto_err, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    beat(1'b1, 1'b0, 1'b1, 1'b0, 1, 0);
    expect_res(3);

    idle(LAT + 4);
    chk("pending results", q.size(), 0);
    chk("pending errors", errq.size(), 0);
    hold = bus.out_data;
    chk("out_data hold", longint'(hold), last_res);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
